// File: rtl/power_of_eight_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : power_of_eight_arbiter
// Purpose : Shares one power-of-eight unit (8^x) among NUM_REQ requesters.
//           Round-robin grant, registered issue, in-order tag FIFO that
//           routes each returning result to the requester that issued it.
// Config  : define PWR_ARB_PRIORITY_EN to give requester 0 fixed priority
//           (round-robin then applies only among requesters 1..NUM_REQ-1).
// Revision: 1.0  initial release
// ============================================================================
module power_of_eight_arbiter #(
  parameter int NUM_REQ         = 4,
  parameter int ID_W            = 2,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic [NUM_REQ-1:0]     i_req_status,
  input  logic [4*NUM_REQ-1:0]   i_req_value,
  output logic [NUM_REQ-1:0]     o_req_ready,
  output logic                   o_unit_status,
  output logic [3:0]             o_unit_value,
  input  logic                   i_unit_status,
  input  logic [60:0]            i_unit_value,
  output logic [NUM_REQ-1:0]     o_rsp_status,
  output logic [60:0]            o_rsp_value,
  output logic [ID_W-1:0]        o_rsp_id,
  output logic                   o_err_unexpected
);

  localparam int c_PTR_W = $clog2(MAX_OUTSTANDING);
  localparam int c_CNT_W = c_PTR_W + 1;

  logic [ID_W-1:0]    r_rr_ptr;
  logic [c_CNT_W-1:0] r_count;
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [ID_W-1:0]    r_fifo_mem [MAX_OUTSTANDING];
  logic               r_unit_status;
  logic [3:0]         r_unit_value;
  logic [NUM_REQ-1:0] r_rsp_status;
  logic [60:0]        r_rsp_value;
  logic [ID_W-1:0]    r_rsp_id;
  logic               r_err;

  logic               w_full;
  logic               w_push;
  logic               w_pop;
  logic               w_orphan;
  logic [NUM_REQ-1:0] w_mask_hi;
  logic [NUM_REQ-1:0] w_masked;
  logic [NUM_REQ-1:0] w_pick;
  logic [NUM_REQ-1:0] w_rr_grant;
  logic [NUM_REQ-1:0] w_grant;
  logic               w_ptr_upd;
  logic [ID_W-1:0]    w_grant_id;
  logic [3:0]         w_sel_value;
  logic [ID_W-1:0]    w_ptr_next;
  logic [ID_W-1:0]    w_head_id;

  // A pop in the same cycle does not free a slot: fullness uses registered count only.
  assign w_full    = (r_count == c_CNT_W'(MAX_OUTSTANDING));

  // Round-robin: prefer requesters at or above the pointer, else wrap to the lowest one.
  assign w_mask_hi  = ~((NUM_REQ'(1) << r_rr_ptr) - NUM_REQ'(1));
  assign w_masked   = i_req_status & w_mask_hi;
  assign w_pick     = (|w_masked) ? w_masked : i_req_status;
  assign w_rr_grant = w_pick & (~w_pick + NUM_REQ'(1));

  // Final grant, gated by FIFO space; priority build lets requester 0 pre-empt without moving the pointer.
  always_comb begin
    w_grant   = '0;
    w_ptr_upd = 1'b0;
    if (!w_full) begin
`ifdef PWR_ARB_PRIORITY_EN
      if (i_req_status[0]) begin
        w_grant = NUM_REQ'(1);
      end else begin
        w_grant   = w_rr_grant;
        w_ptr_upd = |w_rr_grant;
      end
`else
      w_grant   = w_rr_grant;
      w_ptr_upd = |w_rr_grant;
`endif
    end
  end

  // Encode the one-hot grant into an id and select that requester's exponent.
  always_comb begin
    w_grant_id  = '0;
    w_sel_value = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (((w_grant >> k) & NUM_REQ'(1)) != '0) begin
        w_grant_id  = ID_W'(k);
        w_sel_value = 4'(i_req_value >> (4 * k));
      end
    end
  end

  assign w_ptr_next  = (w_grant_id == ID_W'(NUM_REQ - 1)) ? '0 : w_grant_id + ID_W'(1);
  assign w_push      = |w_grant;
  assign w_pop       = i_unit_status && (r_count != '0);
  assign w_orphan    = i_unit_status && (r_count == '0);
  assign w_head_id   = r_fifo_mem[r_rd_ptr];
  assign o_req_ready = w_grant;

  // Round-robin pointer advances past the granted requester.
  always_ff @(posedge i_clock) begin
    if (i_reset)        r_rr_ptr <= '0;
    else if (w_ptr_upd) r_rr_ptr <= w_ptr_next;
  end

  // Tag FIFO storage; contents are don't-care while count is zero.
  always_ff @(posedge i_clock) begin
    if (w_push) r_fifo_mem[r_wr_ptr] <= w_grant_id;
  end

  // Tag FIFO pointers and occupancy.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_CNT_W'(1);
        2'b01:   r_count <= r_count - c_CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Issue register towards the shared unit; value holds between issues.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_unit_status <= 1'b0;
      r_unit_value  <= '0;
    end else begin
      r_unit_status <= w_push;
      if (w_push) r_unit_value <= w_sel_value;
    end
  end

  // Response register: route each result to the id at the FIFO head.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_rsp_status <= '0;
      r_rsp_value  <= '0;
      r_rsp_id     <= '0;
    end else if (w_pop) begin
      r_rsp_status <= NUM_REQ'(1) << w_head_id;
      r_rsp_value  <= i_unit_value;
      r_rsp_id     <= w_head_id;
    end else begin
      r_rsp_status <= '0;
    end
  end

  // Sticky flag for a result that arrives with nothing outstanding.
  always_ff @(posedge i_clock) begin
    if (i_reset)       r_err <= 1'b0;
    else if (w_orphan) r_err <= 1'b1;
  end

  assign o_unit_status    = r_unit_status;
  assign o_unit_value     = r_unit_value;
  assign o_rsp_status     = r_rsp_status;
  assign o_rsp_value      = r_rsp_value;
  assign o_rsp_id         = r_rsp_id;
  assign o_err_unexpected = r_err;

endmodule
`default_nettype wire

// File: tb/tb_power_of_eight_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_power_of_eight_arbiter
// Purpose : Self-checking bench for power_of_eight_arbiter with a behavioural
//           shared unit of configurable latency and a response scoreboard.
// Revision: 1.0  initial release
// ============================================================================
module tb_power_of_eight_arbiter;

  localparam int N    = 4;
  localparam int IDW  = 2;
  localparam int MAXO = 8;
`ifdef PWR_ARB_PRIORITY_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            i_reset;
  logic [N-1:0]    i_req_status;
  logic [4*N-1:0]  i_req_value;
  logic [N-1:0]    o_req_ready;
  logic            o_unit_status;
  logic [3:0]      o_unit_value;
  logic            i_unit_status;
  logic [60:0]     i_unit_value;
  logic [N-1:0]    o_rsp_status;
  logic [60:0]     o_rsp_value;
  logic [IDW-1:0]  o_rsp_id;
  logic            o_err_unexpected;

  always #5 clk = ~clk;

  power_of_eight_arbiter #(.NUM_REQ(N), .ID_W(IDW), .MAX_OUTSTANDING(MAXO)) u_dut (
    .i_clock          (clk),
    .i_reset          (i_reset),
    .i_req_status     (i_req_status),
    .i_req_value      (i_req_value),
    .o_req_ready      (o_req_ready),
    .o_unit_status    (o_unit_status),
    .o_unit_value     (o_unit_value),
    .i_unit_status    (i_unit_status),
    .i_unit_value     (i_unit_value),
    .o_rsp_status     (o_rsp_status),
    .o_rsp_value      (o_rsp_value),
    .o_rsp_id         (o_rsp_id),
    .o_err_unexpected (o_err_unexpected)
  );

  typedef struct { int due; logic [60:0] val; }         unit_t;
  typedef struct { int due; int id; logic [60:0] val; } rsp_t;

  unit_t       uq[$];
  rsp_t        sq[$];
  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  int          lat   = 1;
  int          m_ptr;
  int          m_cnt;
  bit          m_err;
  bit          inj   = 1'b0;
  logic [3:0]  last_uval;
  logic [60:0] last_rval;
  int          last_rid;
  logic [N-1:0] seen_ready;
  int          ngr;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // One clock cycle: check grant, advance model, check registered outputs, drive the unit.
  task automatic step();
    int         gid;
    bit         pop;
    logic [3:0] ex;
    gid = -1;
    ex  = '0;
    #2;
    if (m_cnt < MAXO) begin
      if (PRIO && i_req_status[0]) gid = 0;
      for (int i = 0; i < N && gid < 0; i++) begin
        int idx;
        idx = (m_ptr + i) % N;
        if (((i_req_status >> idx) & 1) != 0) gid = idx;
      end
    end
    check_eq("grant", 64'(o_req_ready), (gid < 0) ? 64'd0 : (64'd1 << gid));
    seen_ready = o_req_ready;
    if (gid >= 0) ex = 4'(i_req_value >> (4 * gid));
    pop = i_unit_status && (m_cnt > 0);
    if (i_unit_status && m_cnt == 0) m_err = 1'b1;
    @(posedge clk);
    cyc++;
    if (gid >= 0) begin
      m_cnt++;
      if (!(PRIO && gid == 0)) m_ptr = (gid + 1) % N;
      sq.push_back('{cyc + lat + 1, gid, 61'(1) << (3 * ex)});
      last_uval = ex;
    end
    if (pop) m_cnt--;
    #1;
    check_eq("unit_status", 64'(o_unit_status), 64'(gid >= 0));
    check_eq("unit_value", 64'(o_unit_value), 64'(last_uval));
    if (sq.size() > 0 && sq[0].due == cyc) begin
      check_eq("rsp_status", 64'(o_rsp_status), 64'd1 << sq[0].id);
      last_rval = sq[0].val;
      last_rid  = sq[0].id;
      void'(sq.pop_front());
    end else begin
      check_eq("rsp_status", 64'(o_rsp_status), 64'd0);
    end
    check_eq("rsp_value", 64'(o_rsp_value), 64'(last_rval));
    check_eq("rsp_id", 64'(o_rsp_id), 64'(last_rid));
    check_eq("err", 64'(o_err_unexpected), 64'(m_err));
    // behavioural shared unit: fixed latency, in order
    if (o_unit_status) uq.push_back('{cyc + lat, 61'(1) << (3 * o_unit_value)});
    if (uq.size() > 0 && uq[0].due == cyc) begin
      i_unit_status = 1'b1;
      i_unit_value  = uq[0].val;
      void'(uq.pop_front());
    end else if (inj) begin
      i_unit_status = 1'b1;
      i_unit_value  = 61'h123;
      inj           = 1'b0;
    end else begin
      i_unit_status = 1'b0;
      i_unit_value  = '0;
    end
  endtask

  // Reset DUT and the behavioural unit together, then check every output is cleared.
  task automatic do_reset();
    i_reset       = 1'b1;
    i_req_status  = '0;
    i_unit_status = 1'b0;
    i_unit_value  = '0;
    @(posedge clk);
    cyc++;
    #1;
    i_reset   = 1'b0;
    m_ptr     = 0;
    m_cnt     = 0;
    m_err     = 1'b0;
    last_uval = '0;
    last_rval = '0;
    last_rid  = 0;
    uq.delete();
    sq.delete();
    check_eq("rst_ready", 64'(o_req_ready), 64'd0);
    check_eq("rst_unit_status", 64'(o_unit_status), 64'd0);
    check_eq("rst_unit_value", 64'(o_unit_value), 64'd0);
    check_eq("rst_rsp_status", 64'(o_rsp_status), 64'd0);
    check_eq("rst_rsp_value", 64'(o_rsp_value), 64'd0);
    check_eq("rst_rsp_id", 64'(o_rsp_id), 64'd0);
    check_eq("rst_err", 64'(o_err_unexpected), 64'd0);
  endtask

  initial begin
    i_reset       = 1'b1;
    i_req_status  = '0;
    i_req_value   = '0;
    i_unit_status = 1'b0;
    i_unit_value  = '0;
    seen_ready    = '0;
    #1;
    do_reset();

    // single request: exponent 3 -> 512 back to lane 0
    lat = 1;
    i_req_status = 4'b0001;
    i_req_value  = 16'h0003;
    step();
    i_req_status = '0;
    repeat (4) step();

    // all lanes continuously, exponents k+1
    i_req_status = 4'b1111;
    i_req_value  = 16'h4321;
    repeat (12) step();
    i_req_status = '0;
    repeat (4) step();

    // long unit latency: FIFO fills at exactly MAXO grants before the first pop
    do_reset();
    lat = 12;
    ngr = 0;
    i_req_status = 4'b1111;
    i_req_value  = 16'h7531;
    repeat (13) begin
      step();
      if (seen_ready != '0) ngr++;
    end
    check_eq("grants_before_pop", 64'(ngr), 64'(MAXO));
    repeat (30) step();
    i_req_status = '0;
    repeat (20) step();
    check_eq("drain_full", 64'(sq.size()), 64'd0);

    // unexpected result with nothing outstanding: sticky error
    lat = 1;
    do_reset();
    inj = 1'b1;
    repeat (6) step();
    do_reset();

    // reset with three operations in flight, unit reset alongside
    lat = 6;
    i_req_status = 4'b0111;
    i_req_value  = 16'h0abc;
    repeat (3) step();
    i_req_status = '0;
    step();
    do_reset();
    i_req_status = 4'b1111;
    i_req_value  = 16'h2468;
    repeat (3) step();
    i_req_status = '0;
    repeat (12) step();

    // lanes 0 and 2 held high: alternate, or lane 0 only under fixed priority
    lat = 12;
    do_reset();
    i_req_status = 4'b0101;
    i_req_value  = 16'h0502;
    repeat (24) step();
    i_req_status = '0;
    repeat (20) step();

    // random traffic
    lat = 3;
    do_reset();
    repeat (200) begin
      i_req_status = N'($urandom_range(0, 15));
      i_req_value  = 16'($urandom);
      step();
    end
    i_req_status = '0;
    repeat (20) step();
    check_eq("drain_final", 64'(sq.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
